// File: rtl/light_seq_monitor_if.sv
// Traffic-light monitor bus: observed lights and clear in, phase/dwell/cycle/fault status out.
// The master modport belongs to whoever drives the lights; the slave modport belongs to the monitor.
interface light_seq_monitor_if #(
  parameter int unsigned CW = 8
);
  logic [2:0]    lights;
  logic          clr;
  logic [1:0]    phase;
  logic [CW-1:0] dwell;
  logic          cycle_done;
  logic [CW-1:0] cycles;
  logic          fault;
  logic [1:0]    err_code;

  modport master (
    output lights, clr,
    input  phase, dwell, cycle_done, cycles, fault, err_code
  );

  modport slave (
    input  lights, clr,
    output phase, dwell, cycle_done, cycles, fault, err_code
  );
endinterface

// File: rtl/light_seq_monitor.sv
// Receive-side checker for the {green,yellow,red} light bus: it tracks the phase order and the
// dwell bounds, counts completed cycles, and latches the first fault cause until it is cleared.
module light_seq_monitor #(
  parameter int unsigned RED_MIN = 1,
  parameter int unsigned RED_MAX = 1,
  parameter int unsigned YEL_MIN = 1,
  parameter int unsigned YEL_MAX = 1,
  parameter int unsigned GRN_MIN = 3,
  parameter int unsigned GRN_MAX = 3,
  parameter int unsigned CW      = 8
) (
  input logic Clk,
  input logic Reset,
  light_seq_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_YEL,
    S_GRN,
    S_FAULT
  } state_t;

  localparam logic [2:0]    C_RED = 3'b001;
  localparam logic [2:0]    C_YEL = 3'b010;
  localparam logic [2:0]    C_GRN = 3'b100;
  localparam logic [CW-1:0] SAT   = '1;

  localparam logic [CW:0] RED_MIN_W = (CW+1)'(RED_MIN);
  localparam logic [CW:0] RED_MAX_W = (CW+1)'(RED_MAX);
  localparam logic [CW:0] YEL_MIN_W = (CW+1)'(YEL_MIN);
  localparam logic [CW:0] YEL_MAX_W = (CW+1)'(YEL_MAX);
  localparam logic [CW:0] GRN_MIN_W = (CW+1)'(GRN_MIN);
  localparam logic [CW:0] GRN_MAX_W = (CW+1)'(GRN_MAX);

  state_t        state, state_n;
  logic [1:0]    phase_q, phase_n;
  logic [CW-1:0] dwell_q, dwell_n;
  logic          done_q, done_n;
  logic [CW-1:0] cycles_q, cycles_n;
  logic          fault_q, fault_n;
  logic [1:0]    err_q, err_n;

  logic [2:0]    cur_code, nxt_code;
  state_t        nxt_state;
  logic [CW:0]   min_w, max_w, dwell_inc;
  logic          legal, go_fault;
  logic [1:0]    go_code;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      phase_q  <= 2'd0;
      dwell_q  <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
      fault_q  <= 1'b0;
      err_q    <= 2'd0;
    end else begin
      state    <= state_n;
      phase_q  <= phase_n;
      dwell_q  <= dwell_n;
      done_q   <= done_n;
      cycles_q <= cycles_n;
      fault_q  <= fault_n;
      err_q    <= err_n;
    end
  end

  // Per-phase view: the code that extends the current phase, the code that legally follows it, and its dwell bounds.
  always_comb begin
    cur_code  = C_RED;
    nxt_code  = C_YEL;
    nxt_state = S_YEL;
    min_w     = RED_MIN_W;
    max_w     = RED_MAX_W;
    case (state)
      S_YEL: begin
        cur_code  = C_YEL;
        nxt_code  = C_GRN;
        nxt_state = S_GRN;
        min_w     = YEL_MIN_W;
        max_w     = YEL_MAX_W;
      end
      S_GRN: begin
        cur_code  = C_GRN;
        nxt_code  = C_RED;
        nxt_state = S_RED;
        min_w     = GRN_MIN_W;
        max_w     = GRN_MAX_W;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    dwell_n   = dwell_q;
    done_n    = 1'b0;
    cycles_n  = cycles_q;
    fault_n   = fault_q;
    err_n     = err_q;
    go_fault  = 1'b0;
    go_code   = 2'd0;
    legal     = (bus.lights == C_RED) || (bus.lights == C_YEL) || (bus.lights == C_GRN);
    dwell_inc = {1'b0, dwell_q} + (CW+1)'(1);

    case (state)
      S_IDLE: begin
        if (bus.lights == C_RED) begin
          state_n = S_RED;
          dwell_n = CW'(1);
        end else if (!legal) begin
          go_fault = 1'b1;
          go_code  = 2'd1;
        end
      end
      S_RED, S_YEL, S_GRN: begin
        if (!legal) begin
          go_fault = 1'b1;
          go_code  = 2'd1;
        end else if (bus.lights == cur_code) begin
          if (dwell_inc > max_w) begin
            go_fault = 1'b1;
            go_code  = 2'd3;
          end else begin
            dwell_n = dwell_inc[CW] ? SAT : dwell_inc[CW-1:0];
          end
        end else if (bus.lights == nxt_code) begin
          if ({1'b0, dwell_q} < min_w) begin
            go_fault = 1'b1;
            go_code  = 2'd3;
          end else begin
            state_n = nxt_state;
            dwell_n = CW'(1);
            if (state == S_GRN) begin
              done_n = 1'b1;
              if (cycles_q != SAT) cycles_n = cycles_q + CW'(1);
            end
          end
        end else begin
          go_fault = 1'b1;
          go_code  = 2'd2;
        end
      end
      S_FAULT: begin
        if (bus.clr) begin
          state_n = S_IDLE;
          fault_n = 1'b0;
          err_n   = 2'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Fault can only be entered from a non-fault state, so the latched cause is always the first one.
    if (go_fault) begin
      state_n = S_FAULT;
      dwell_n = '0;
      fault_n = 1'b1;
      err_n   = go_code;
    end

    case (state_n)
      S_RED:   phase_n = 2'd1;
      S_YEL:   phase_n = 2'd2;
      S_GRN:   phase_n = 2'd3;
      default: phase_n = 2'd0;
    endcase
  end

  assign bus.phase      = phase_q;
  assign bus.dwell      = dwell_q;
  assign bus.cycle_done = done_q;
  assign bus.cycles     = cycles_q;
  assign bus.fault      = fault_q;
  assign bus.err_code   = err_q;

endmodule

// File: tb/tb_light_seq_monitor.sv
// Scoreboard bench for light_seq_monitor: directed light sequences on a CW=8 and a CW=2 instance,
// expected status pushed at drive time and popped/compared by a per-instance monitor after each edge.
module tb_light_seq_monitor;

  typedef struct {
    int ph;
    int dw;
    int dn;
    int cy;
    int fl;
    int er;
  } exp_t;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic Clk;
  logic rst8, rst2;
  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q2[$];
  exp_t e8, e2;

  light_seq_monitor_if #(.CW(8)) bus8 ();
  light_seq_monitor_if #(.CW(2)) bus2 ();

  light_seq_monitor #(.CW(8)) dut8 (
    .Clk   (Clk),
    .Reset (rst8),
    .bus   (bus8)
  );

  light_seq_monitor #(.CW(2)) dut2 (
    .Clk   (Clk),
    .Reset (rst2),
    .bus   (bus2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic checkSample(input string tag, input exp_t e, input int ph, input int dw,
                             input int dn, input int cy, input int fl, input int er);
    checkOutput({tag, ".phase"}, ph, e.ph);
    checkOutput({tag, ".dwell"}, dw, e.dw);
    checkOutput({tag, ".cycle_done"}, dn, e.dn);
    checkOutput({tag, ".cycles"}, cy, e.cy);
    checkOutput({tag, ".fault"}, fl, e.fl);
    checkOutput({tag, ".err_code"}, er, e.er);
  endtask

  // One sample per cycle: drive on the falling edge, queue what the next rising edge must produce.
  task automatic applyStimulus(input int dut, input logic [2:0] l, input logic c, input logic r,
                               input int ph, input int dw, input int dn, input int cy,
                               input int fl, input int er);
    exp_t e;
    @(negedge Clk);
    e.ph = ph; e.dw = dw; e.dn = dn; e.cy = cy; e.fl = fl; e.er = er;
    if (dut == 8) begin
      bus8.lights = l;
      bus8.clr    = c;
      rst8        = r;
      q8.push_back(e);
    end else begin
      bus2.lights = l;
      bus2.clr    = c;
      rst2        = r;
      q2.push_back(e);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      checkSample("dut8", e8, int'(bus8.phase), int'(bus8.dwell), int'(bus8.cycle_done),
                  int'(bus8.cycles), int'(bus8.fault), int'(bus8.err_code));
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      checkSample("dut2", e2, int'(bus2.phase), int'(bus2.dwell), int'(bus2.cycle_done),
                  int'(bus2.cycles), int'(bus2.fault), int'(bus2.err_code));
    end
  end

  initial begin
    int prev;
    int cnt;
    rst8 = 1'b1; rst2 = 1'b1;
    bus8.lights = 3'b000; bus8.clr = 1'b0;
    bus2.lights = 3'b000; bus2.clr = 1'b0;

    // Reset, then two legal cycles
    applyStimulus(8, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(8, Y, 0, 0, 2, 1, 0, 0, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 1, 0, 0, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 2, 0, 0, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 3, 0, 0, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 1, 1, 0, 0);
    applyStimulus(8, Y, 0, 0, 2, 1, 0, 1, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 1, 0, 1, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 2, 0, 1, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 3, 0, 1, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 1, 2, 0, 0);

    // Illegal code in RED, sticky fault, then clear (cycles kept)
    applyStimulus(8, 3'b011, 0, 0, 0, 0, 0, 2, 1, 1);
    applyStimulus(8, R, 0, 0, 0, 0, 0, 2, 1, 1);
    applyStimulus(8, Y, 0, 0, 0, 0, 0, 2, 1, 1);
    applyStimulus(8, Y, 1, 0, 0, 0, 0, 2, 0, 0);

    // Sync-up in IDLE: green/yellow ignored until red
    applyStimulus(8, G, 0, 0, 0, 0, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 0, 0, 0, 2, 0, 0);
    applyStimulus(8, Y, 0, 0, 0, 0, 0, 2, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 0, 2, 0, 0);

    // GREEN left too early
    applyStimulus(8, Y, 0, 0, 2, 1, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 1, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 2, 0, 2, 0, 0);
    applyStimulus(8, R, 0, 0, 0, 0, 0, 2, 1, 3);
    applyStimulus(8, R, 1, 0, 0, 0, 0, 2, 0, 0);

    // RED held too long
    applyStimulus(8, R, 0, 0, 1, 1, 0, 2, 0, 0);
    applyStimulus(8, R, 0, 0, 0, 0, 0, 2, 1, 3);
    applyStimulus(8, R, 1, 0, 0, 0, 0, 2, 0, 0);

    // Order violation, later illegal code keeps the first cause
    applyStimulus(8, R, 0, 0, 1, 1, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 0, 0, 0, 2, 1, 2);
    applyStimulus(8, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2);
    applyStimulus(8, 3'b000, 1, 0, 0, 0, 0, 2, 0, 0);

    // YELLOW held too long
    applyStimulus(8, R, 0, 0, 1, 1, 0, 2, 0, 0);
    applyStimulus(8, Y, 0, 0, 2, 1, 0, 2, 0, 0);
    applyStimulus(8, Y, 0, 0, 0, 0, 0, 2, 1, 3);
    applyStimulus(8, Y, 1, 0, 0, 0, 0, 2, 0, 0);

    // GREEN held too long
    applyStimulus(8, R, 0, 0, 1, 1, 0, 2, 0, 0);
    applyStimulus(8, Y, 0, 0, 2, 1, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 1, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 2, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 3, 0, 2, 0, 0);
    applyStimulus(8, G, 0, 0, 0, 0, 0, 2, 1, 3);

    // Reset wins over clr in FAULT; clr is ignored outside FAULT
    applyStimulus(8, R, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(8, Y, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(8, Y, 1, 0, 2, 1, 0, 0, 0, 0);
    applyStimulus(8, G, 0, 0, 3, 1, 0, 0, 0, 0);

    // Reset mid-GREEN, then the monitor must wait for red again
    applyStimulus(8, G, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(8, G, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(8, R, 0, 0, 1, 1, 0, 0, 0, 0);

    // Narrow counters: the cycle count saturates at 3 while cycle_done keeps pulsing
    applyStimulus(2, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, R, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      prev = (k - 1 > 3) ? 3 : k - 1;
      cnt  = (k > 3) ? 3 : k;
      applyStimulus(2, Y, 0, 0, 2, 1, 0, prev, 0, 0);
      applyStimulus(2, G, 0, 0, 3, 1, 0, prev, 0, 0);
      applyStimulus(2, G, 0, 0, 3, 2, 0, prev, 0, 0);
      applyStimulus(2, G, 0, 0, 3, 3, 0, prev, 0, 0);
      applyStimulus(2, R, 0, 0, 1, 1, 1, cnt, 0, 0);
    end
    applyStimulus(2, Y, 0, 0, 2, 1, 0, 3, 0, 0);
    applyStimulus(2, G, 0, 0, 3, 1, 0, 3, 0, 0);
    applyStimulus(2, G, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, G, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge Clk);
    #3;
    checkOutput("queue8.drained", q8.size(), 0);
    checkOutput("queue2.drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/light_seq_monitor.md
Name: light_seq_monitor

Overview:
- Receive-side checker for the 3-bit traffic-light bus {green, yellow, red} driven by the team's light sequencer.
- Samples the bus every rising clock edge and tracks the current phase.
- Enforces legal phase order (RED -> YELLOW -> GREEN -> RED) and per-phase dwell bounds.
- Reports completed cycles and latches a sticky fault with a cause code; used in integration benches and as an on-chip safety monitor.

Parameters:
RED_MIN, 1, minimum RED dwell in sampled cycles (>=1)
RED_MAX, 1, maximum RED dwell (>=RED_MIN)
YEL_MIN, 1, minimum YELLOW dwell
YEL_MAX, 1, maximum YELLOW dwell
GRN_MIN, 3, minimum GREEN dwell
GRN_MAX, 3, maximum GREEN dwell
CW, 8, width of dwell counter and cycle counter

Ports:
Clk  input  1  clock; all sampling and state updates on rising edge
Reset  input  1  synchronous, active-high reset
lights  input  3  observed bus; bit0=red, bit1=yellow, bit2=green
clr  input  1  synchronous fault clear, returns monitor to IDLE
phase  output  2  0=IDLE/FAULT, 1=RED, 2=YELLOW, 3=GREEN
dwell  output  CW  cycles spent in current phase, including the entry cycle
cycle_done  output  1  one-cycle pulse on each legal GREEN->RED transition
cycles  output  CW  count of completed cycles, saturating at all-ones
fault  output  1  sticky fault flag
err_code  output  2  0=none, 1=illegal code, 2=order violation, 3=dwell violation

Behaviour:
- All outputs are registered and update on the same edge that samples lights; no extra pipeline stage.
- Reset (sync, high) has priority over everything, including clr.
- Reset values: state=IDLE, phase=0, dwell=0, cycle_done=0, cycles=0, fault=0, err_code=0.
- Legal codes are 100 (red), 010 (yellow), 001 (green), written as bit0,bit1,bit2. Any other value (000, 011, 101, 110, 111) is illegal.
- States: IDLE, RED, YELLOW, GREEN, FAULT. For state S, next(S) is RED->YELLOW, YELLOW->GREEN, GREEN->RED.
- IDLE:
  - red -> RED, dwell=1.
  - yellow or green -> stay IDLE; sync-up, no error.
  - illegal code -> FAULT, err=1.
- RED, YELLOW, GREEN, evaluated in this priority:
  1. Illegal code -> FAULT, err=1.
  2. Code equals S: dwell+1; if dwell+1 > MAX(S) -> FAULT, err=3.
  3. Code equals next(S): if dwell < MIN(S) -> FAULT, err=3. Otherwise state=next(S), dwell=1.
  4. Any other legal code -> FAULT, err=2.
- On a legal GREEN->RED transition: cycle_done=1 for that cycle; cycles+1, saturating at 2^CW-1 (no wrap).
- dwell saturates at 2^CW-1. The MAX check fires before saturation whenever MAX < 2^CW-1.
- FAULT:
  - Entering FAULT sets phase=0 and dwell=0; fault and err_code are latched.
  - Further violations do not overwrite err_code; the first cause wins.
  - cycles is held in FAULT.
  - clr=1 -> IDLE, fault=0, err_code=0; cycles is kept.
  - clr is ignored outside FAULT.
- cycle_done is 0 in every cycle except the legal-wrap cycle; it never pulses in IDLE or FAULT.
- Reset asserted mid-phase: the next edge gives full reset values, and the monitor must re-sync on red.

Test Plan:
- Reset, then drive red,yellow,green,green,green,red,yellow,green,green,green,red -> phase 1,2,3,3,3,1,...; dwell 1,1,1,2,3,1,...; cycle_done high exactly on the 6th and 11th samples; cycles=2; fault=0.
- From IDLE, drive green,green,yellow, then red -> stays IDLE for 3 cycles, enters RED on the 4th; no fault.
- In RED, drive 110 -> next edge fault=1, err_code=1, phase=0. Then red,yellow -> still fault. Then clr=1 -> IDLE, err_code=0.
- red,yellow,green,green,red (GREEN dwell 2 < GRN_MIN=3) -> fault, err_code=3. Separately, red,red (RED dwell 2 > RED_MAX=1) -> fault on the 2nd sample, err_code=3.
- red then green (skips yellow) -> fault, err_code=2. A subsequent illegal code 000 leaves err_code=2.
- CW=2: run 4 legal cycles -> cycles saturates at 3, cycle_done still pulses on the 4th wrap. Assert Reset mid-GREEN together with clr -> all outputs zero next edge.
